// File: rtl/enemy_formation.sv
// Invader formation controller: origin, march/descent timing, floor/extinction and shooter pick.
// Define FORMATION_SPEEDUP_EN to shorten the step period as enemies are killed.
module enemy_formation #(
  parameter int unsigned ROWS        = 3,
  parameter int unsigned COLS        = 8,
  parameter int unsigned X0          = 150,
  parameter int unsigned Y0          = 40,
  parameter int unsigned DX          = 60,
  parameter int unsigned DY          = 50,
  parameter int unsigned ENEMY_W     = 40,
  parameter int unsigned ENEMY_H     = 30,
  parameter int unsigned STEP_X      = 20,
  parameter int unsigned STEP_Y      = 25,
  parameter int unsigned LEFT_LIMIT  = 10,
  parameter int unsigned RIGHT_LIMIT = 630,
  parameter int unsigned FLOOR_Y     = 420,
  parameter int unsigned BASE_PERIOD = 2000000,
  parameter int unsigned MIN_PERIOD  = 200000,
  parameter int unsigned SPEEDUP     = 75000,
  localparam int unsigned N          = ROWS * COLS,
  localparam int unsigned IDW        = $clog2(N)
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           start_i,
  input  logic           freeze_i,
  input  logic [N-1:0]   alive_i,
  output logic [10:0]    base_x_o,
  output logic [10:0]    base_y_o,
  output logic           direction_o,
  output logic           step_pulse_o,
  output logic           reached_floor_o,
  output logic           all_dead_o,
  output logic           fire_valid_o,
  output logic [IDW-1:0] fire_id_o,
  input  logic           fire_ready_i
);

  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {StIdle, StMarch, StHalt} state_e;

  state_e          state_q, state_d;
  logic [31:0]     counter_q, counter_d;
  logic [10:0]     base_x_q, base_x_d, base_y_q, base_y_d;
  logic            dir_q, dir_d, step_pulse_q, step_pulse_d;
  logic            floor_q, floor_d, dead_q, dead_d;
  logic            fire_valid_q, fire_valid_d;
  logic [IDW-1:0]  fire_id_q, fire_id_d;
  logic [7:0]      lfsr_q, lfsr_d, lfsr_nxt;
  logic            srch_q, srch_d;
  logic [CW-1:0]   col_q, col_d, cnt_q, cnt_d;

  logic [COLS-1:0] col_alive;
  logic [ROWS-1:0] row_alive;
  int unsigned     top_row [COLS];
  int unsigned     lcol, rcol, brow, period;
  logic            any_alive, tick, floor_hit;

  // Per-column / per-row occupancy and the formation's living extent.
  always_comb begin
    col_alive = '0;
    row_alive = '0;
    lcol = 0;
    rcol = 0;
    brow = 0;
    for (int unsigned c = 0; c < COLS; c++) top_row[c] = 0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        if (alive_i[r*COLS+c]) begin
          col_alive[c] = 1'b1;
          row_alive[r] = 1'b1;
          top_row[c]   = r;
        end
      end
    end
    for (int unsigned i = 0; i < COLS; i++) begin
      if (col_alive[COLS-1-i]) lcol = COLS - 1 - i;
      if (col_alive[i]) rcol = i;
    end
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (row_alive[r]) brow = r;
    end
  end

  assign any_alive = |alive_i;

`ifdef FORMATION_SPEEDUP_EN
  int unsigned killed, reduce;
  always_comb begin
    killed = N;
    for (int unsigned i = 0; i < N; i++) killed = killed - {31'd0, alive_i[i]};
    reduce = killed * SPEEDUP;
    // Clamp before subtracting so a large kill count cannot wrap the period.
    period = (reduce >= BASE_PERIOD - MIN_PERIOD) ? MIN_PERIOD : BASE_PERIOD - reduce;
  end
`else
  always_comb period = BASE_PERIOD;
`endif

  assign tick = (state_q == StMarch) && !freeze_i && any_alive && (counter_q >= period - 1);

  always_comb begin
    base_x_d = base_x_q;
    base_y_d = base_y_q;
    dir_d    = dir_q;
    if (tick) begin
      if (!dir_q && (32'(base_x_q) + rcol*DX + ENEMY_W - 1 + STEP_X > RIGHT_LIMIT)) begin
        base_y_d = base_y_q + 11'(STEP_Y);
        dir_d    = 1'b1;
      end else if (dir_q && (32'(base_x_q) + lcol*DX < LEFT_LIMIT + STEP_X)) begin
        base_y_d = base_y_q + 11'(STEP_Y);
        dir_d    = 1'b0;
      end else if (!dir_q) begin
        base_x_d = base_x_q + 11'(STEP_X);
      end else begin
        base_x_d = base_x_q - 11'(STEP_X);
      end
    end
  end

  assign floor_hit = tick && (32'(base_y_d) + brow*DY + ENEMY_H >= FLOOR_Y);

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StMarch;
      StMarch: if (!freeze_i && (!any_alive || floor_hit)) state_d = StHalt;
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  assign lfsr_nxt = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // Output / datapath next-state logic
  always_comb begin
    counter_d    = counter_q;
    step_pulse_d = tick;
    floor_d      = floor_q | floor_hit;
    dead_d       = dead_q | ((state_q == StMarch) && !freeze_i && !any_alive);
    fire_valid_d = fire_valid_q;
    fire_id_d    = fire_id_q;
    lfsr_d       = lfsr_q;
    srch_d       = srch_q;
    col_d        = col_q;
    cnt_d        = cnt_q;
    if (state_q == StIdle && start_i) begin
      counter_d = '0;
    end else if (state_q == StMarch && !freeze_i) begin
      counter_d = tick ? '0 : counter_q + 32'd1;
    end
    // Drop a pending request once accepted or once its shooter has died.
    if (fire_valid_q && (fire_ready_i || !alive_i[fire_id_q])) fire_valid_d = 1'b0;
    if (state_q == StMarch && !freeze_i) begin
      if (srch_q) begin
        if (col_alive[col_q]) begin
          fire_valid_d = 1'b1;
          fire_id_d    = IDW'(top_row[col_q] * COLS + 32'(col_q));
          srch_d       = 1'b0;
        end else if (cnt_q == CW'(COLS - 1)) begin
          srch_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;
        end
      end else if (tick && !fire_valid_q) begin
        lfsr_d = lfsr_nxt;
        col_d  = CW'(32'(lfsr_nxt) % COLS);
        cnt_d  = '0;
        srch_d = 1'b1;
      end
    end
    if (state_q != StMarch) begin
      fire_valid_d = 1'b0;
      srch_d       = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      counter_q    <= '0;
      base_x_q     <= 11'(X0);
      base_y_q     <= 11'(Y0);
      dir_q        <= 1'b0;
      step_pulse_q <= 1'b0;
      floor_q      <= 1'b0;
      dead_q       <= 1'b0;
      fire_valid_q <= 1'b0;
      fire_id_q    <= '0;
      lfsr_q       <= 8'hA5;
      srch_q       <= 1'b0;
      col_q        <= '0;
      cnt_q        <= '0;
    end else begin
      counter_q    <= counter_d;
      base_x_q     <= base_x_d;
      base_y_q     <= base_y_d;
      dir_q        <= dir_d;
      step_pulse_q <= step_pulse_d;
      floor_q      <= floor_d;
      dead_q       <= dead_d;
      fire_valid_q <= fire_valid_d;
      fire_id_q    <= fire_id_d;
      lfsr_q       <= lfsr_d;
      srch_q       <= srch_d;
      col_q        <= col_d;
      cnt_q        <= cnt_d;
    end
  end

  assign base_x_o        = base_x_q;
  assign base_y_o        = base_y_q;
  assign direction_o     = dir_q;
  assign step_pulse_o    = step_pulse_q;
  assign reached_floor_o = floor_q;
  assign all_dead_o      = dead_q;
  assign fire_valid_o    = fire_valid_q;
  assign fire_id_o       = fire_id_q;

endmodule

// File: tb/tb_enemy_formation.sv
// Randomised bench for enemy_formation with a behavioural march/fire model and directed scenarios.
module tb_enemy_formation;
  localparam int ROWS = 3, COLS = 8, N = 24, IDW = 5;
  localparam int BASE = 10, MINP = 4, SPD = 1;
  localparam int X0 = 150, Y0 = 40, DX = 60, DY = 50, EW = 40, EH = 30;
  localparam int STX = 20, STY = 25, LL = 10, RL = 630, FL = 420;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, freeze = 1'b0, fire_ready = 1'b0;
  logic [N-1:0] alive = '1;
  logic [10:0] base_x, base_y;
  logic direction, step_pulse, reached_floor, all_dead, fire_valid;
  logic [IDW-1:0] fire_id;

  int n_checks = 0, n_errors = 0;
  int m_st = 0, m_x = X0, m_y = Y0, m_cnt = 0;
  bit m_dir = 0, m_pulse = 0, m_floor = 0, m_dead = 0;

  enemy_formation #(.BASE_PERIOD(BASE), .MIN_PERIOD(MINP), .SPEEDUP(SPD)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .freeze_i(freeze), .alive_i(alive),
    .base_x_o(base_x), .base_y_o(base_y), .direction_o(direction), .step_pulse_o(step_pulse),
    .reached_floor_o(reached_floor), .all_dead_o(all_dead), .fire_valid_o(fire_valid),
    .fire_id_o(fire_id), .fire_ready_i(fire_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_period(input logic [N-1:0] a);
`ifdef FORMATION_SPEEDUP_EN
    int p;
    p = BASE - (N - $countones(a)) * SPD;
    return (p < MINP) ? MINP : p;
`else
    return BASE;
`endif
  endfunction

  // Index of the shooter a column would supply: its highest-index living row, -1 if empty.
  function automatic int top_id(input logic [N-1:0] a, input int c);
    top_id = -1;
    for (int r = 0; r < ROWS; r++) if (a[r*COLS+c]) top_id = r * COLS + c;
  endfunction

  task automatic model_move();
    int lc, rc, br;
    lc = -1; rc = -1; br = 0;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (alive[r*COLS+c]) begin
          if (lc < 0) lc = c;
          rc = c;
          if (r > br) br = r;
        end
    if (!m_dir) begin
      if (m_x + rc*DX + EW - 1 + STX > RL) begin m_y += STY; m_dir = 1; end
      else m_x += STX;
    end else begin
      if (m_x + lc*DX - STX < LL) begin m_y += STY; m_dir = 0; end
      else m_x -= STX;
    end
    if (m_y + br*DY + EH >= FL) begin m_floor = 1; m_st = 2; end
  endtask

  task automatic model_edge();
    m_pulse = 0;
    if (reset) begin
      m_st = 0; m_x = X0; m_y = Y0; m_dir = 0; m_floor = 0; m_dead = 0; m_cnt = 0;
    end else if (m_st == 0) begin
      if (start) begin m_st = 1; m_cnt = 0; end
    end else if (m_st == 1 && !freeze) begin
      if (alive == '0) begin m_dead = 1; m_st = 2; end
      else if (m_cnt >= exp_period(alive) - 1) begin m_cnt = 0; m_pulse = 1; model_move(); end
      else m_cnt++;
    end
  endtask

  task automatic step();
    logic [N-1:0] a_e;
    logic rdy_e, rst_e, fv_b;
    logic [IDW-1:0] fid_b;
    int st_b;
    a_e = alive; rdy_e = fire_ready; rst_e = reset; fv_b = fire_valid; fid_b = fire_id;
    st_b = m_st;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check("march", {6'd0, base_x, base_y, direction, step_pulse, reached_floor, all_dead},
          {6'd0, 11'(m_x), 11'(m_y), m_dir, m_pulse, m_floor, m_dead});
    if (!rst_e) begin
      if (fire_valid) check("fire_target", 32'(fire_id), top_id(a_e, int'(fire_id) % COLS));
      if (fv_b === 1'b1 && (rdy_e || !a_e[fid_b])) check("fire_clear", 32'(fire_valid), 0);
      else if (fv_b === 1'b1 && st_b == 1)
        check("fire_hold", {26'd0, fire_valid, fire_id}, {26'd0, 1'b1, fid_b});
      if (st_b == 2) check("halt_no_fire", 32'(fire_valid), 0);
    end
  endtask

  task automatic do_reset();
    reset = 1; start = 0; freeze = 0; fire_ready = 0;
    step();
    reset = 0;
  endtask

  task automatic do_start();
    start = 1;
    step();
    start = 0;
  endtask

  task automatic wait_pulse(input int bound, output int n);
    n = 0;
    do begin step(); n++; end while (!step_pulse && n < bound);
    check("pulse_seen", 32'(step_pulse), 1);
  endtask

  initial begin
    int n, pulses, prev_x, idx;
    logic [N-1:0] mask;

    do_reset();
    check("reset_vals", {6'd0, base_x, base_y, direction, step_pulse, reached_floor, all_dead},
          {6'd0, 11'd150, 11'd40, 4'd0});
    check("reset_fire", {26'd0, fire_valid, fire_id}, 0);

    // First two ticks with the full grid.
    alive = '1; fire_ready = 1;
    do_start();
    wait_pulse(100, n);
    check("first_tick_lat", n, 10);
    check("first_tick_x", 32'(base_x), 170);
    wait_pulse(100, n);
    check("second_tick_lat", n, 10);
    check("second_tick_pos", {base_x, base_y, direction}, {11'd170, 11'd65, 1'b1});

    // Outer columns dead: edge follows the rightmost living column.
    do_reset();
    mask = '0;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < 6; c++) mask[r*COLS+c] = 1'b1;
    alive = mask;
    do_start();
    prev_x = int'(base_x);
    for (int k = 0; k < 20 && base_y == 11'd40; k++) begin
      prev_x = int'(base_x);
      wait_pulse(50, n);
    end
    check("desc_prev_x", prev_x, 290);
    check("desc_pos", {base_x, base_y, direction}, {11'd290, 11'd65, 1'b1});

    // Kill-driven period.
    do_reset();
    alive = '1; alive[2:0] = 3'b000;
    do_start();
    wait_pulse(100, n);
    check("period_3_kills", n, exp_period(alive));
`ifdef FORMATION_SPEEDUP_EN
    check("period_3_abs", n, 7);
`else
    check("period_3_abs", n, 10);
`endif
    do_reset();
    alive = '1; alive[9:0] = '0;
    do_start();
    wait_pulse(100, n);
    check("period_10_kills", n, exp_period(alive));

    // Fire handshake with a single living enemy at column 2, row 0.
    do_reset();
    alive = '0; alive[2] = 1'b1;
    do_start();
    n = 0;
    while (!fire_valid && n < 300) begin step(); n++; end
    check("fire_seen", 32'(fire_valid), 1);
    check("fire_id", 32'(fire_id), 2);
    for (int k = 0; k < 5; k++) step();
    check("fire_stable", {26'd0, fire_valid, fire_id}, {26'd0, 1'b1, 5'd2});
    fire_ready = 1;
    step();
    check("fire_accept", 32'(fire_valid), 0);

    // Extinction mid-march, then reset.
    do_reset();
    alive = '1;
    do_start();
    for (int k = 0; k < 25; k++) step();
    alive = '0;
    step();
    check("all_dead", {30'd0, all_dead, reached_floor}, {30'd0, 2'b10});
    pulses = 0;
    for (int k = 0; k < 30; k++) begin step(); pulses += int'(step_pulse); end
    check("dead_no_step", pulses, 0);
    alive = '1;
    do_reset();
    check("rst_after_dead", {6'd0, base_x, base_y, direction, step_pulse, reached_floor, all_dead},
          {6'd0, 11'd150, 11'd40, 4'd0});
    pulses = 0;
    for (int k = 0; k < 20; k++) begin step(); pulses += int'(step_pulse); end
    check("idle_hold", {21'd0, base_x}, {21'd0, 11'd150});
    check("idle_no_step", pulses, 0);

    // Random kills, freeze and ready until the formation reaches the floor.
    do_start();
    n = 0;
    while (!reached_floor && !all_dead && n < 8000) begin
      freeze = ($urandom_range(7) == 0);
      fire_ready = ($urandom_range(2) == 0);
      if ($urandom_range(39) == 0) begin
        idx = $urandom_range(N - 1);
        if ($countones(alive) > 1) alive[idx] = 1'b0;
      end
      step();
      n++;
    end
    freeze = 0;
    check("floor_reached", {30'd0, reached_floor, all_dead}, {30'd0, 2'b10});
    pulses = 0;
    for (int k = 0; k < 40; k++) begin step(); pulses += int'(step_pulse); end
    check("floor_no_step", pulses, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
